// File: rtl/flash_key_sched.sv
// Arbitrates debounced SE/WR/RD key requests onto the SPI-flash op engines.
// Grants in priority SE > WR > RD, waits for done (or timeout), then holds a guard gap.
module flash_key_sched #(
    parameter logic [19:0] GAP_MAX     = 20'd999,
    parameter logic [27:0] TIMEOUT_MAX = 28'd199_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_flag_se,
    input  logic       key_flag_wr,
    input  logic       key_flag_rd,
    input  logic       op_done,
    output logic       se_start,
    output logic       wr_start,
    output logic       rd_start,
    output logic [1:0] cur_op,
    output logic       busy,
    output logic       err_timeout
);

    localparam logic [27:0] GapLast     = {8'd0, GAP_MAX} - 28'd1;
    localparam logic [27:0] TimeoutLast = TIMEOUT_MAX - 28'd1;

    typedef enum logic [1:0] {StIdle, StStart, StWaitDone, StGap} state_e;

    state_e      state;
    logic [2:0]  pending;   // [0] SE, [1] WR, [2] RD
    logic [27:0] counter;
    logic [2:0]  grant;
    logic [1:0]  grant_op;
    logic [2:0]  key_flags;

    assign key_flags = {key_flag_rd, key_flag_wr, key_flag_se};

    always_comb begin
        grant    = 3'b000;
        grant_op = 2'd0;
        if (pending[0]) begin
            grant    = 3'b001;
            grant_op = 2'd1;
        end else if (pending[1]) begin
            grant    = 3'b010;
            grant_op = 2'd2;
        end else if (pending[2]) begin
            grant    = 3'b100;
            grant_op = 2'd3;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= StIdle;
            pending     <= 3'b000;
            counter     <= 28'd0;
            se_start    <= 1'b0;
            wr_start    <= 1'b0;
            rd_start    <= 1'b0;
            cur_op      <= 2'd0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            // A flag on the grant edge re-arms the bit being cleared.
            pending     <= (state == StIdle ? (pending & ~grant) : pending) | key_flags;
            se_start    <= 1'b0;
            wr_start    <= 1'b0;
            rd_start    <= 1'b0;
            err_timeout <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (|pending) begin
                        state    <= StStart;
                        cur_op   <= grant_op;
                        busy     <= 1'b1;
                        counter  <= 28'd0;
                        se_start <= grant[0];
                        wr_start <= grant[1];
                        rd_start <= grant[2];
                    end
                end
                StStart: begin
                    // Timeout budget is measured from the start strobe.
                    state   <= StWaitDone;
                    counter <= counter + 28'd1;
                end
                StWaitDone: begin
                    if (op_done) begin
                        state   <= StGap;
                        counter <= 28'd0;
                    end else if (counter >= TimeoutLast) begin
                        state       <= StGap;
                        counter     <= 28'd0;
                        err_timeout <= 1'b1;
                    end else begin
                        counter <= counter + 28'd1;
                    end
                end
                StGap: begin
                    if (counter >= GapLast) begin
                        state   <= StIdle;
                        counter <= 28'd0;
                        cur_op  <= 2'd0;
                        busy    <= 1'b0;
                    end else begin
                        counter <= counter + 28'd1;
                    end
                end
                default: begin
                    state   <= StIdle;
                    counter <= 28'd0;
                    cur_op  <= 2'd0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_key_sched.sv
// Scoreboard bench for flash_key_sched: expected strobe/timeout events are queued with
// their cycle numbers and matched against what the scheduler emits.
module tb_flash_key_sched;

    typedef struct {
        int kind;   // 1 SE start, 2 WR start, 3 RD start, 4 timeout
        int cyc;
    } ev_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_flag_se = 1'b0;
    logic       key_flag_wr = 1'b0;
    logic       key_flag_rd = 1'b0;
    logic       resp_done = 1'b0;
    logic       stray_done = 1'b0;
    logic       op_done;
    logic       se_start;
    logic       wr_start;
    logic       rd_start;
    logic [1:0] cur_op;
    logic       busy;
    logic       err_timeout;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_lat = 3;
    ev_t  exp_q[$];

    assign op_done = resp_done | stray_done;

    flash_key_sched #(
        .GAP_MAX    (20'd4),
        .TIMEOUT_MAX(28'd20)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_flag_se(key_flag_se),
        .key_flag_wr(key_flag_wr),
        .key_flag_rd(key_flag_rd),
        .op_done    (op_done),
        .se_start   (se_start),
        .wr_start   (wr_start),
        .rd_start   (rd_start),
        .cur_op     (cur_op),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Event monitor: every strobe or timeout pulse must match the queue head.
    initial begin
        logic [3:0] hits;
        ev_t        ev;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n) begin
                hits = {err_timeout, rd_start, wr_start, se_start};
                for (int k = 1; k <= 4; k++) begin
                    if (hits[k-1]) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL event: got kind %0d at cycle %0d, required no event",
                                     k, cyc);
                        end else begin
                            ev = exp_q.pop_front();
                            if (ev.kind !== k || ev.cyc !== cyc) begin
                                errors++;
                                $display("FAIL event: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                                         k, cyc, ev.kind, ev.cyc);
                            end
                        end
                    end
                end
            end
        end
    end

    // Engine model: answers each start strobe with op_done after done_lat cycles.
    initial begin
        int lat;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && (se_start || wr_start || rd_start) && done_lat >= 0) begin
                lat = done_lat;
                repeat (lat) @(posedge sys_clk);
                #1 resp_done = 1'b1;
                @(posedge sys_clk);
                #1 resp_done = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        @(negedge sys_clk);
        while (cyc < n) @(negedge sys_clk);
    endtask

    // Drives keys {rd, wr, se} high for len cycles starting in cycle at.
    task automatic key_pulse(input logic [2:0] b, input int at, input int len);
        while (cyc < at) begin
            @(posedge sys_clk);
            #1;
        end
        key_flag_se = b[0];
        key_flag_wr = b[1];
        key_flag_rd = b[2];
        repeat (len) @(posedge sys_clk);
        #1;
        key_flag_se = 1'b0;
        key_flag_wr = 1'b0;
        key_flag_rd = 1'b0;
    endtask

    task automatic stray_at(input int at);
        while (cyc < at) begin
            @(posedge sys_clk);
            #1;
        end
        stray_done = 1'b1;
        @(posedge sys_clk);
        #1 stray_done = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({se_start, wr_start, rd_start, busy, err_timeout, cur_op} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 0000000",
                     {se_start, wr_start, rd_start, busy, err_timeout, cur_op});
        end
        #2 sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0 || cur_op !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle: got busy %b cur_op %0d, required 0 0", busy, cur_op);
        end
    endtask

    task automatic test_single();
        int k;
        done_lat = 5;
        k = cyc + 2;
        exp_q.push_back('{3, k + 2});
        key_pulse(3'b100, k, 1);
        wait_cyc(k + 2);
        checks++;
        if (busy !== 1'b1 || cur_op !== 2'd3) begin
            errors++;
            $display("FAIL single_active: got busy %b cur_op %0d, required 1 3", busy, cur_op);
        end
        wait_cyc(k + 11);
        checks++;
        if (busy !== 1'b1 || cur_op !== 2'd3) begin
            errors++;
            $display("FAIL single_gap_end: got busy %b cur_op %0d, required 1 3", busy, cur_op);
        end
        wait_cyc(k + 12);
        checks++;
        if (busy !== 1'b0 || cur_op !== 2'd0) begin
            errors++;
            $display("FAIL single_idle: got busy %b cur_op %0d, required 0 0", busy, cur_op);
        end
    endtask

    task automatic test_priority();
        int k;
        done_lat = 3;
        k = cyc + 2;
        exp_q.push_back('{1, k + 2});
        exp_q.push_back('{2, k + 11});
        exp_q.push_back('{3, k + 20});
        key_pulse(3'b111, k, 1);
        wait_cyc(k + 28);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL priority_drain: got %0d pending events busy %b, required 0 0",
                     exp_q.size(), busy);
        end
    endtask

    task automatic test_timeout();
        int k;
        done_lat = -1;
        k = cyc + 2;
        exp_q.push_back('{2, k + 2});
        exp_q.push_back('{4, k + 22});
        key_pulse(3'b010, k, 1);
        wait_cyc(k + 25);
        checks++;
        if (busy !== 1'b1 || cur_op !== 2'd2) begin
            errors++;
            $display("FAIL timeout_gap: got busy %b cur_op %0d, required 1 2", busy, cur_op);
        end
        wait_cyc(k + 26);
        checks++;
        if (busy !== 1'b0 || cur_op !== 2'd0) begin
            errors++;
            $display("FAIL timeout_idle: got busy %b cur_op %0d, required 0 0", busy, cur_op);
        end
        wait_cyc(k + 45);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_events: got %0d outstanding, required 0", exp_q.size());
        end
        done_lat = 3;
    endtask

    task automatic test_same_edge();
        int k;
        done_lat = 3;
        // Second cycle of the flag coincides with the grant edge.
        k = cyc + 2;
        exp_q.push_back('{1, k + 2});
        exp_q.push_back('{1, k + 11});
        key_pulse(3'b001, k, 2);
        wait_cyc(k + 25);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL same_edge: got %0d outstanding busy %b, required 0 0",
                     exp_q.size(), busy);
        end
        // Four SE flags during a WR operation coalesce into one request.
        k = cyc + 2;
        exp_q.push_back('{2, k + 2});
        exp_q.push_back('{1, k + 11});
        key_pulse(3'b010, k, 1);
        key_pulse(3'b001, k + 3, 1);
        key_pulse(3'b001, k + 5, 1);
        key_pulse(3'b001, k + 7, 1);
        key_pulse(3'b001, k + 9, 1);
        wait_cyc(k + 30);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL coalesce: got %0d outstanding busy %b, required 0 0",
                     exp_q.size(), busy);
        end
    endtask

    task automatic test_mid_reset();
        int k;
        int r;
        done_lat = -1;
        k = cyc + 2;
        exp_q.push_back('{2, k + 2});
        key_pulse(3'b010, k, 1);
        key_pulse(3'b110, k + 4, 1);
        wait_cyc(k + 7);
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({se_start, wr_start, rd_start, busy, err_timeout, cur_op} !== 7'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b, required 0000000",
                     {se_start, wr_start, rd_start, busy, err_timeout, cur_op});
        end
        @(negedge sys_clk);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        done_lat = 3;
        r = cyc;
        wait_cyc(r + 30);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0 || cur_op !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got %0d outstanding busy %b cur_op %0d, required 0 0 0",
                     exp_q.size(), busy, cur_op);
        end
        k = cyc + 2;
        exp_q.push_back('{3, k + 2});
        key_pulse(3'b100, k, 1);
        wait_cyc(k + 14);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_resume: got %0d outstanding busy %b, required 0 0",
                     exp_q.size(), busy);
        end
    endtask

    task automatic test_stray_done();
        int k;
        done_lat = 3;
        k = cyc + 2;
        stray_at(k);
        wait_cyc(k + 2);
        checks++;
        if (busy !== 1'b0 || cur_op !== 2'd0) begin
            errors++;
            $display("FAIL stray_idle: got busy %b cur_op %0d, required 0 0", busy, cur_op);
        end
        k = cyc + 2;
        exp_q.push_back('{3, k + 2});
        key_pulse(3'b100, k, 1);
        stray_at(k + 7);
        wait_cyc(k + 9);
        checks++;
        if (busy !== 1'b1 || cur_op !== 2'd3) begin
            errors++;
            $display("FAIL stray_gap_len: got busy %b cur_op %0d, required 1 3", busy, cur_op);
        end
        wait_cyc(k + 10);
        checks++;
        if (busy !== 1'b0 || cur_op !== 2'd0) begin
            errors++;
            $display("FAIL stray_gap_end: got busy %b cur_op %0d, required 0 0", busy, cur_op);
        end
        wait_cyc(k + 20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stray_events: got %0d outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_timeout();
        test_same_edge();
        test_mid_reset();
        test_stray_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
